// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined, chunked carry-lookahead adder/subtractor with a valid/ready stream.
// Optional signed saturation is built only when CLA_SAT_EN is defined.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    typedef struct packed {
        logic             v;
        logic             sat;
        logic             c;
        logic             cm;
        logic             o;
        logic             z;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } beat_t;

    beat_t pin [STAGES];
    beat_t nxt [STAGES];
    beat_t pq  [STAGES];
    logic  adv;
    logic  unused_bits;

    // c[i] = OR_j (g[j] & p[j+1..i-1]) | (p[0..i-1] & c0), flattened per bit
    function automatic logic [CW:0] cla(
        input logic [CW-1:0] g,
        input logic [CW-1:0] p,
        input logic          c0
    );
        logic [CW:0] c;
        logic        t;
        c    = '0;
        c[0] = c0;
        for (int i = 1; i <= CW; i++) begin
            t = c0;
            for (int j = 0; j < i; j++) t = t & p[j];
            c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return c;
    endfunction

    function automatic beat_t stage_f(input beat_t d, input int k);
        beat_t         r;
        logic [CW-1:0] g;
        logic [CW-1:0] p;
        logic [CW:0]   c;
        g = d.a[k*CW +: CW] & d.b[k*CW +: CW];
        p = d.a[k*CW +: CW] ^ d.b[k*CW +: CW];
        c = cla(g, p, d.c);
        r = d;
        r.s[k*CW +: CW] = p ^ c[CW-1:0];
        r.c  = c[CW];
        r.cm = c[CW-1];
        return r;
    endfunction

    always_comb begin
        pin[0]   = '0;
        pin[0].v = in_valid;
`ifdef CLA_SAT_EN
        pin[0].sat = sat;
`endif
        pin[0].c = cin ^ sub;
        pin[0].a = a;
        pin[0].b = sub ? ~b : b;
        for (int k = 1; k < STAGES; k++) pin[k] = pq[k-1];
        for (int k = 0; k < STAGES; k++) nxt[k] = stage_f(pin[k], k);
        // flags use the raw sum; zero is taken after any clamp
        nxt[L].o = nxt[L].c ^ nxt[L].cm;
`ifdef CLA_SAT_EN
        if (nxt[L].sat && nxt[L].o)
            nxt[L].s = nxt[L].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        nxt[L].z = (nxt[L].s == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) pq[k] <= '0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) pq[k] <= nxt[k];
        end
    end

    // lower operand bits and mid-pipe flag fields are dead by design
    always_comb begin
        unused_bits = sat;
        for (int k = 0; k < STAGES; k++) unused_bits = unused_bits ^ (^pq[k]);
    end

    assign adv       = !pq[L].v || out_ready;
    assign in_ready  = adv;
    assign out_valid = pq[L].v;
    assign sum       = pq[L].s;
    assign cout      = pq[L].c;
    assign ovf       = pq[L].o;
    assign zero      = pq[L].z;

endmodule
